// File: rtl/aes192_pkg.sv
// AES-192 key schedule shared definitions.
// Constants, word types, Rcon and the S-box table.
package aes192_pkg;

    localparam int NK        = 6;
    localparam int NR        = 12;
    localparam int NUM_RK    = 13;
    localparam int NUM_WORDS = 52;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    localparam logic [7:0] RCON [8] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes192_round_key_streamer_if.sv
// Start/key request and round key valid/ready stream.
// slave: the key streamer; master: the requester/consumer.
interface aes192_round_key_streamer_if;
    import aes192_pkg::*;

    logic                         start;
    logic [191:0]                 key;
    logic                         rk_ready;
    logic                         rk_valid;
    rkey_t                        rk;
    logic [$clog2(NR+1)-1:0]      rk_idx;
    logic                         busy;
    logic                         done;

    modport master (
        output start, key, rk_ready,
        input  rk_valid, rk, rk_idx, busy, done
    );

    modport slave (
        input  start, key, rk_ready,
        output rk_valid, rk, rk_idx, busy, done
    );

endinterface

// File: rtl/aes_sub_word.sv
// AES SubWord: four parallel S-box byte lookups.
// Purely combinational.
module aes_sub_word
    import aes192_pkg::*;
(
    input  word_t a,
    output word_t y
);

    assign y = {sbox(a[31:24]), sbox(a[23:16]),
                sbox(a[15:8]),  sbox(a[7:0])};

endmodule

// File: rtl/aes192_round_key_streamer.sv
// Iterative AES-192 key schedule, one word per cycle,
// packed into 13 round keys on a valid/ready stream.
module aes192_round_key_streamer #(
    parameter int NK     = aes192_pkg::NK,
    parameter int NUM_RK = aes192_pkg::NUM_RK
) (
    input logic                         clk,
    input logic                         rst,
    aes192_round_key_streamer_if.slave  bus
);
    import aes192_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);
    localparam logic [5:0] WORDS    = 6'(NUM_WORDS);
    localparam logic [5:0] NKW      = 6'(NK);
    localparam logic [2:0] PH_MAX   = 3'(NK - 1);

    word_t       win [NK];
    logic [95:0] acc;
    logic [1:0]  cnt;
    logic [5:0]  wi;
    logic [2:0]  ph;
    logic [2:0]  rci;
    logic        busy_q;
    logic        done_q;
    logic        rk_valid_q;
    rkey_t       rk_q;
    logic [3:0]  rk_idx_q;

    word_t rot;
    word_t sub;
    word_t tmp;
    word_t nw;
    logic  accept;
    logic  gen;
    logic  xfer;
    logic  slot_free;
    logic  adv;
    logic  load;
    logic  last_hs;

    aes_sub_word u_sub (
        .a (rot),
        .y (sub)
    );

    assign accept    = bus.start && !busy_q;
    assign gen       = busy_q && (wi < WORDS);
    assign xfer      = rk_valid_q && bus.rk_ready;
    assign slot_free = !rk_valid_q || bus.rk_ready;
    assign adv       = gen && ((cnt != 2'd3) || slot_free);
    assign load      = adv && (cnt == 2'd3);
    assign last_hs   = xfer && (rk_idx_q == LAST_IDX);

    assign rot = {win[NK-1][23:0], win[NK-1][31:24]};
    assign tmp = (ph == 3'd0) ? (sub ^ {RCON[rci], 24'h0})
                              : win[NK-1];
    assign nw  = (wi < NKW) ? win[ph] : (win[0] ^ tmp);

    // Load the key window on start, then advance one word per free edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NK; k++) win[k] <= '0;
            acc    <= '0;
            cnt    <= '0;
            wi     <= '0;
            ph     <= '0;
            rci    <= '0;
            busy_q <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < NK; k++)
                win[k] <= bus.key[32*(NK-1-k) +: 32];
            cnt    <= '0;
            wi     <= '0;
            ph     <= '0;
            rci    <= '0;
            busy_q <= 1'b1;
        end else begin
            if (adv) begin
                wi  <= wi + 6'd1;
                ph  <= (ph == PH_MAX) ? 3'd0 : ph + 3'd1;
                cnt <= cnt + 2'd1;
                acc <= {acc[63:0], nw};
                if (wi >= NKW) begin
                    for (int k = 0; k < NK-1; k++)
                        win[k] <= win[k+1];
                    win[NK-1] <= nw;
                    if (ph == 3'd0) rci <= rci + 3'd1;
                end
            end
            if (last_hs) busy_q <= 1'b0;
        end
    end

    // Round key output slot and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_q       <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (load) begin
                rk_q       <= {acc, nw};
                rk_idx_q   <= wi[5:2];
                rk_valid_q <= 1'b1;
            end else if (xfer) begin
                rk_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rk_valid = rk_valid_q;
    assign bus.rk       = rk_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_aes192_round_key_streamer.sv
// Directed bench for the AES-192 round key streamer.
// Reference keys come from an independent schedule model.
module tb_aes192_round_key_streamer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes192_round_key_streamer_if bus ();

    aes192_round_key_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [191:0] KEY_A =
        192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] KEY_B =
        192'hdeadbeef0badf00dcafebabe123456789abcdef011223344;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sb [256];
    logic [31:0]  rw [52];
    logic [127:0] got_rk [13];
    logic [3:0]   got_idx [13];
    int           hs_c [13];
    int           ngot, ndone, done_c;
    int           stall_n, stall_bad, busy_drop;
    logic         done_busy, done_valid;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse plus the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sb[x] = s ^ 8'h63;
        end
    endtask

    task automatic expand_ref(input logic [191:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 6; i++) rw[i] = k[191-32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = rw[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]],
                     sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            rw[i] = rw[i-6] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {rw[4*r], rw[4*r+1], rw[4*r+2], rw[4*r+3]};
    endfunction

    task automatic do_start(input logic [191:0] k);
        bus.key   = k;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.key   = ~k;
    endtask

    // Drives rk_ready per mode and records every handshake.
    // mode 0: always ready, 1: 10-cycle stall on rk1, 2: random.
    task automatic collect(input int mode, input int tail,
                           input int sb_cycle);
        logic r;
        ngot = 0; ndone = 0; done_c = -1;
        stall_n = 0; stall_bad = 0; busy_drop = 0;
        done_busy = 1'b1; done_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (bus.done) begin
                ndone++;
                if (done_c < 0) begin
                    done_c     = c;
                    done_busy  = bus.busy;
                    done_valid = bus.rk_valid;
                end
            end
            if (done_c >= 0 && c - done_c >= tail) break;
            if (ngot < 13 && !bus.busy) busy_drop++;
            if (c == sb_cycle - 1) begin
                bus.start = 1'b1;
                bus.key   = KEY_B;
            end else begin
                bus.start = 1'b0;
            end
            r = 1'b1;
            if (mode == 1) begin
                if (bus.rk_valid && bus.rk_idx == 4'd1 &&
                    stall_n < 10) begin
                    r = 1'b0;
                    stall_n++;
                    if (bus.rk !== ref_rk(1)) stall_bad++;
                end
            end else if (mode == 2) begin
                r = 1'($urandom_range(0, 1));
            end
            bus.rk_ready = r;
            if (bus.rk_valid && r && ngot < 13) begin
                got_rk[ngot]  = bus.rk;
                got_idx[ngot] = bus.rk_idx;
                hs_c[ngot]    = c;
                ngot++;
            end
            @(posedge clk);
            #1;
        end
        bus.rk_ready = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rk_valid: got %b want 0", bus.rk_valid);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_done: got %b%b want 00",
                     bus.busy, bus.done);
        end
        n_checks++;
        if (bus.rk !== 128'h0 || bus.rk_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_rk: got %h/%0d want 0/0",
                     bus.rk, bus.rk_idx);
        end
    endtask

    task automatic test_nominal();
        expand_ref(KEY_A);
        do_start(KEY_A);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nom_busy_after_start: got %b want 1", bus.busy);
        end
        collect(0, 3, 0);
        n_checks++;
        if (ngot !== 13) begin
            n_fail++;
            $display("FAIL nom_count: got %0d want 13", ngot);
        end
        for (int r = 0; r < 13; r++) begin
            n_checks++;
            if (got_rk[r] !== ref_rk(r) || got_idx[r] !== 4'(r)) begin
                n_fail++;
                $display("FAIL nom_rk%0d: got %h/%0d want %h/%0d", r,
                         got_rk[r], got_idx[r], ref_rk(r), r);
            end
        end
        n_checks++;
        if (got_rk[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_fail++;
            $display("FAIL nom_rk0_vec: got %h", got_rk[0]);
        end
        n_checks++;
        if (got_rk[1] !== 128'h10111213141516175846f2f95c43f4fe) begin
            n_fail++;
            $display("FAIL nom_rk1_vec: got %h", got_rk[1]);
        end
        n_checks++;
        if (got_rk[12] !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin
            n_fail++;
            $display("FAIL nom_rk12_vec: got %h", got_rk[12]);
        end
        n_checks++;
        if (hs_c[0] !== 4 || hs_c[1] !== 8 || hs_c[12] !== 52) begin
            n_fail++;
            $display("FAIL nom_latency: got %0d/%0d/%0d want 4/8/52",
                     hs_c[0], hs_c[1], hs_c[12]);
        end
        n_checks++;
        if (done_c !== 53 || ndone !== 1) begin
            n_fail++;
            $display("FAIL nom_done: got cycle %0d count %0d want 53 1",
                     done_c, ndone);
        end
        n_checks++;
        if (done_busy !== 1'b0 || done_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_done_state: got busy %b valid %b want 0 0",
                     done_busy, done_valid);
        end
        n_checks++;
        if (busy_drop !== 0) begin
            n_fail++;
            $display("FAIL nom_busy_hold: got %0d drops want 0", busy_drop);
        end
        n_checks++;
        if (bus.rk !== ref_rk(12) || bus.rk_idx !== 4'd12) begin
            n_fail++;
            $display("FAIL nom_rk_hold: got %h/%0d want %h/12",
                     bus.rk, bus.rk_idx, ref_rk(12));
        end
    endtask

    task automatic test_backpressure();
        expand_ref(KEY_A);
        do_start(KEY_A);
        collect(1, 3, 0);
        n_checks++;
        if (stall_n !== 10 || stall_bad !== 0) begin
            n_fail++;
            $display("FAIL bp_stall: got %0d cycles %0d bad want 10 0",
                     stall_n, stall_bad);
        end
        n_checks++;
        if (ngot !== 13 || ndone !== 1) begin
            n_fail++;
            $display("FAIL bp_count: got %0d keys %0d done want 13 1",
                     ngot, ndone);
        end
        for (int r = 0; r < 13; r++) begin
            n_checks++;
            if (got_rk[r] !== ref_rk(r) || got_idx[r] !== 4'(r)) begin
                n_fail++;
                $display("FAIL bp_rk%0d: got %h/%0d want %h/%0d", r,
                         got_rk[r], got_idx[r], ref_rk(r), r);
            end
        end
        n_checks++;
        if (hs_c[1] !== 18 || hs_c[2] !== 19 || hs_c[12] !== 59) begin
            n_fail++;
            $display("FAIL bp_timing: got %0d/%0d/%0d want 18/19/59",
                     hs_c[1], hs_c[2], hs_c[12]);
        end
    endtask

    task automatic test_random_ready();
        expand_ref(KEY_A);
        do_start(KEY_A);
        collect(2, 3, 0);
        n_checks++;
        if (ngot !== 13 || ndone !== 1) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d keys %0d done want 13 1",
                     ngot, ndone);
        end
        for (int r = 0; r < 13; r++) begin
            n_checks++;
            if (got_rk[r] !== ref_rk(r) || got_idx[r] !== 4'(r)) begin
                n_fail++;
                $display("FAIL rnd_rk%0d: got %h/%0d want %h/%0d", r,
                         got_rk[r], got_idx[r], ref_rk(r), r);
            end
        end
    endtask

    task automatic test_start_while_busy();
        expand_ref(KEY_A);
        do_start(KEY_A);
        collect(0, 3, 20);
        n_checks++;
        if (busy_drop !== 0 || ngot !== 13) begin
            n_fail++;
            $display("FAIL swb_busy: got %0d drops %0d keys want 0 13",
                     busy_drop, ngot);
        end
        for (int r = 0; r < 13; r++) begin
            n_checks++;
            if (got_rk[r] !== ref_rk(r)) begin
                n_fail++;
                $display("FAIL swb_rk%0d: got %h want %h", r,
                         got_rk[r], ref_rk(r));
            end
        end
        n_checks++;
        if (hs_c[12] !== 52 || done_c !== 53) begin
            n_fail++;
            $display("FAIL swb_timing: got %0d/%0d want 52/53",
                     hs_c[12], done_c);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        expand_ref(KEY_A);
        do_start(KEY_A);
        bus.rk_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            if (bus.rk_valid && bus.rk_idx == 4'd5) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_wait: got no rk5 want rk5 valid");
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_flags: got v%b b%b d%b want 000",
                     bus.rk_valid, bus.busy, bus.done);
        end
        n_checks++;
        if (bus.rk !== 128'h0 || bus.rk_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid_rk: got %h/%0d want 0/0",
                     bus.rk, bus.rk_idx);
        end
        bus.rk_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_start(KEY_A);
        collect(0, 3, 0);
        n_checks++;
        if (hs_c[0] !== 4 || got_rk[0] !== ref_rk(0)) begin
            n_fail++;
            $display("FAIL rstmid_rk0: got %h at %0d want %h at 4",
                     got_rk[0], hs_c[0], ref_rk(0));
        end
        n_checks++;
        if (ngot !== 13 || got_rk[12] !== ref_rk(12)) begin
            n_fail++;
            $display("FAIL rstmid_rk12: got %h (%0d keys) want %h",
                     got_rk[12], ngot, ref_rk(12));
        end
    endtask

    task automatic test_restart_on_done();
        expand_ref(KEY_A);
        do_start(KEY_A);
        collect(0, 0, 0);
        n_checks++;
        if (done_c !== 53 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_done_cycle: got %0d d%b b%b want 53 1 0",
                     done_c, bus.done, bus.busy);
        end
        do_start(192'h0);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_accept: got busy %b want 1", bus.busy);
        end
        expand_ref(192'h0);
        collect(0, 3, 0);
        n_checks++;
        if (hs_c[0] !== 4 || got_rk[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL rs_rk0: got %h at %0d want 0 at 4",
                     got_rk[0], hs_c[0]);
        end
        n_checks++;
        if (got_rk[1] !== 128'h00000000000000006263636362636363) begin
            n_fail++;
            $display("FAIL rs_rk1_vec: got %h", got_rk[1]);
        end
        for (int r = 0; r < 13; r++) begin
            n_checks++;
            if (got_rk[r] !== ref_rk(r)) begin
                n_fail++;
                $display("FAIL rs_rk%0d: got %h want %h", r,
                         got_rk[r], ref_rk(r));
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.key      = '0;
        bus.rk_ready = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_nominal();
        test_backpressure();
        test_random_ready();
        test_start_while_busy();
        test_reset_mid();
        test_restart_on_done();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
